// File: rtl/spi_wb_bridge.sv
// SPI mode-0 responder that turns host frames into Wishbone master cycles.
// SPI pins are synchronised into clk; SCK never clocks any logic.
module spi_wb_bridge #(
  parameter int unsigned sync_stages = 2,
  parameter int unsigned wb_timeout  = 255
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        spi_sck,
  input  logic        spi_cs,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA_W, S_TURN, S_DATA_R, S_DONE
  } state_t;

  localparam int unsigned TopS    = sync_stages - 1;
  localparam logic [15:0] TmoLast = 16'(wb_timeout - 1);

  logic [sync_stages-1:0] sck_sq, cs_sq, mosi_sq;
  logic                   sck_prev_q, cs_prev_q;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall, cs_rise, cs_fall;

  state_t      state_q;
  logic [2:0]  bit_cnt_q;
  logic [3:0]  byte_cnt_q;
  logic [7:0]  sh_q;
  logic        cmd_we_q;
  logic [3:0]  cmd_sel_q;
  logic [31:0] adr_sh_q, dat_sh_q, mosr_q;
  logic        skip_q;

  logic        cyc_q, stb_q, we_q, timeout_q;
  logic [31:0] adr_q, dat_q;
  logic [3:0]  sel_q;
  logic [15:0] tmo_cnt_q;
  logic        pend_q, pend_we_q, pend_own_q, cyc_own_q;
  logic [31:0] pend_adr_q, pend_dat_q, rdata_q;
  logic [3:0]  pend_sel_q;
  logic        rd_valid_q;

  logic        active, byte_done, req_rd, req_wr, req_new;
  logic [7:0]  byte_in;
  logic [31:0] req_adr, req_dat;

  // cs syncs reset high so releasing reset never looks like a frame start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_sq     <= '0;
      cs_sq      <= '1;
      mosi_sq    <= '0;
      sck_prev_q <= 1'b0;
      cs_prev_q  <= 1'b1;
    end else begin
      sck_sq     <= {sck_sq[TopS-1:0], spi_sck};
      cs_sq      <= {cs_sq[TopS-1:0], spi_cs};
      mosi_sq    <= {mosi_sq[TopS-1:0], spi_mosi};
      sck_prev_q <= sck_sq[TopS];
      cs_prev_q  <= cs_sq[TopS];
    end
  end

  always_comb begin
    sck_s     = sck_sq[TopS];
    cs_s      = cs_sq[TopS];
    mosi_s    = mosi_sq[TopS];
    sck_rise  = sck_s & ~sck_prev_q;
    sck_fall  = ~sck_s & sck_prev_q;
    cs_rise   = cs_s & ~cs_prev_q;
    cs_fall   = ~cs_s & cs_prev_q;
    active    = (state_q != S_IDLE) && (state_q != S_DONE);
    byte_in   = {sh_q[6:0], mosi_s};
    byte_done = active && sck_rise && (bit_cnt_q == 3'd7) && !cs_rise && !cs_fall;
    req_rd    = byte_done && (state_q == S_ADDR) && (byte_cnt_q == 4'd4) && !cmd_we_q;
    req_wr    = byte_done && (state_q == S_DATA_W) && (byte_cnt_q == 4'd8);
    req_new   = req_rd | req_wr;
    req_adr   = req_rd ? {adr_sh_q[23:0], byte_in} : adr_sh_q;
    req_dat   = req_wr ? {dat_sh_q[23:0], byte_in} : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      sh_q       <= '0;
      cmd_we_q   <= 1'b0;
      cmd_sel_q  <= '0;
      adr_sh_q   <= '0;
      dat_sh_q   <= '0;
      mosr_q     <= '0;
      skip_q     <= 1'b0;
    end else if (cs_rise || cs_fall) begin
      state_q    <= cs_fall ? S_CMD : S_IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      mosr_q     <= '0;
      skip_q     <= 1'b0;
    end else begin
      if (sck_rise && active) begin
        sh_q      <= byte_in;
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      if (byte_done) begin
        byte_cnt_q <= byte_cnt_q + 4'd1;
        case (state_q)
          S_CMD: begin
            cmd_we_q  <= byte_in[7];
            cmd_sel_q <= byte_in[3:0];
            state_q   <= S_ADDR;
          end
          S_ADDR: begin
            adr_sh_q <= {adr_sh_q[23:0], byte_in};
            if (byte_cnt_q == 4'd4) state_q <= cmd_we_q ? S_DATA_W : S_TURN;
          end
          S_DATA_W: begin
            dat_sh_q <= {dat_sh_q[23:0], byte_in};
            if (byte_cnt_q == 4'd8) state_q <= S_DONE;
          end
          // The SCK fall that closes the turnaround byte must not shift out the MSB
          S_TURN: begin
            state_q <= S_DATA_R;
            mosr_q  <= rd_valid_q ? rdata_q : '1;
            skip_q  <= 1'b1;
          end
          S_DATA_R: begin
            if (byte_cnt_q == 4'd9) begin
              state_q <= S_DONE;
              mosr_q  <= '0;
            end
          end
          default: ;
        endcase
      end else if (sck_fall && (state_q == S_DATA_R)) begin
        if (skip_q) skip_q <= 1'b0;
        else        mosr_q <= {mosr_q[30:0], 1'b0};
      end
    end
  end

  // A request made while a cycle is outstanding waits in the pend_* registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      tmo_cnt_q  <= '0;
      timeout_q  <= 1'b0;
      pend_q     <= 1'b0;
      pend_we_q  <= 1'b0;
      pend_adr_q <= '0;
      pend_dat_q <= '0;
      pend_sel_q <= '0;
      pend_own_q <= 1'b0;
      cyc_own_q  <= 1'b0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (req_new) begin
        pend_we_q  <= req_wr;
        pend_adr_q <= req_adr;
        pend_dat_q <= req_dat;
        pend_sel_q <= cmd_sel_q;
        pend_own_q <= req_rd;
      end else if (cs_rise) begin
        pend_own_q <= 1'b0;
      end
      if (cs_rise) cyc_own_q <= 1'b0;
      if (req_rd) rd_valid_q <= 1'b0;
      if (cyc_q) begin
        if (req_new) pend_q <= 1'b1;
        if (wb_ack_i) begin
          cyc_q <= 1'b0;
          stb_q <= 1'b0;
          we_q  <= 1'b0;
          if (!we_q && cyc_own_q && !cs_rise) begin
            rdata_q    <= wb_dat_i;
            rd_valid_q <= 1'b1;
          end
        end else if (tmo_cnt_q == TmoLast) begin
          cyc_q     <= 1'b0;
          stb_q     <= 1'b0;
          we_q      <= 1'b0;
          timeout_q <= 1'b1;
        end else begin
          tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
      end else if (pend_q) begin
        cyc_q     <= 1'b1;
        stb_q     <= 1'b1;
        we_q      <= pend_we_q;
        adr_q     <= pend_adr_q;
        dat_q     <= pend_dat_q;
        sel_q     <= pend_sel_q;
        cyc_own_q <= pend_own_q & ~cs_rise;
        tmo_cnt_q <= '0;
        pend_q    <= req_new;
      end else if (req_new) begin
        cyc_q     <= 1'b1;
        stb_q     <= 1'b1;
        we_q      <= req_wr;
        adr_q     <= req_adr;
        dat_q     <= req_dat;
        sel_q     <= cmd_sel_q;
        cyc_own_q <= req_rd;
        tmo_cnt_q <= '0;
      end
    end
  end

  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;
  assign wb_we_o  = we_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_q;
  assign busy     = cyc_q;
  assign timeout  = timeout_q;
  assign spi_miso = mosr_q[31];

endmodule

// File: doc/spi_wb_bridge.md
Name: spi_wb_bridge

Overview:
- SPI responder (mode 0, MSB first) that lets an external SPI host drive Wishbone read/write cycles as a bus master.
- The conbus connects it as master m2, for example for board bring-up or debug access from a host MCU.
- It is the other end of the SPI link that wb_spi drives as initiator.
- All SPI inputs are asynchronous to clk. They are synchronised and edge-detected internally, and no logic is clocked by SCK.

Parameters:
- sync_stages, 2: flip-flops in the synchroniser on spi_sck, spi_cs and spi_mosi (minimum 2).
- wb_timeout, 255: clk cycles to wait for wb_ack_i before the cycle is abandoned (range 1..65535).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- wb_adr_o  out  32  Wishbone address.
- wb_dat_o  out  32  Wishbone write data.
- wb_dat_i  in  32  Wishbone read data.
- wb_sel_o  out  4  byte selects.
- wb_we_o  out  1  write enable.
- wb_cyc_o  out  1  cycle.
- wb_stb_o  out  1  strobe.
- wb_ack_i  in  1  acknowledge.
- spi_sck  in  1  SPI clock from the host, idle low.
- spi_cs  in  1  chip select, active low.
- spi_mosi  in  1  host-to-bridge data.
- spi_miso  out  1  bridge-to-host data.
- busy  out  1  high while a Wishbone cycle is outstanding.
- timeout  out  1  one-clk pulse when a Wishbone cycle is abandoned.

Behaviour:
- Reset values: all wb_* outputs 0, spi_miso 0, busy 0, timeout 0. The frame state returns to IDLE and the byte/bit counters clear.
- Clock ratio: clk must be at least 8x the SCK frequency.
- Synchronised edges: rise and fall of SCK are detected on synchronised samples. The frame starts on the synchronised falling edge of spi_cs.
- MOSI sampling: MOSI is sampled on each detected SCK rise and shifted in MSB first. A byte completes on every 8th rise.
- Frame layout: byte0 CMD, where bit7 = we, bits3:0 = sel and bits6:4 are ignored. Bytes 1-4 are ADR[31:0], big-endian.
- Write frame: bytes 5-8 are DAT[31:0]. After byte 8 completes, the bridge asserts cyc, stb and we with adr, dat and sel on the next clk.
- Read frame: after byte 4 completes, the bridge asserts cyc and stb with we=0 on the next clk. Byte 5 is turnaround and MISO is 0 during it. Bytes 6-9 shift out the read data MSB first.
- Data-phase load: the MISO shift register loads at the completion of byte 5, and the MSB appears on spi_miso in the same clk.
- MISO shifting: later bits change on each detected SCK fall. MISO is 0 outside the read data phase.
- Read data source: read data is latched on wb_ack_i. If the cycle is still pending or timed out at load time, the bridge loads 0xFFFFFFFF instead.
- Cycle termination: cyc and stb drop in the clk after ack. busy equals cyc.
- Timeout: if wb_timeout clks pass with no ack, cyc and stb drop and timeout pulses for 1 clk. The counter starts at cycle assertion.
- Frame FSM: IDLE -> CMD -> ADDR -> (DATA_W | TURN -> DATA_R) -> DONE. In DONE, further bytes are ignored and MISO stays 0 until CS rises.
- CS rise: CS rising at any point returns the FSM to IDLE within 1 clk of the synchronised edge and clears the counters.
- CS rise during a cycle: an outstanding Wishbone cycle is never cut short by CS. It completes by ack or timeout, and any read data is discarded.
- Partial frames: a write frame aborted before byte 8 completes issues no cycle. A read frame aborted before byte 4 completes issues no cycle.
- New frame while busy: the new frame is decoded normally. Its cycle request is held until the previous cycle ends and then issues on the next clk.
- Write-data masking: wb_dat_o carries the full 32-bit value. wb_sel_o is passed through unchanged, including sel=0.

Test Plan:
- Write, normal case: frame 0x8F, 0x00000010, 0xCAFEBABE with ack after 2 clks. Expect exactly one cycle with adr 0x10, dat 0xCAFEBABE, sel 0xF, we=1. cyc drops 1 clk after ack, and busy mirrors cyc.
- Read, normal case: frame 0x0F, 0x70000000, dummy, then 4 clocked bytes, with the slave returning 0x12345678 with ack after 3 clks. MISO bytes 6-9 must read 0x12,0x34,0x56,0x78 and MISO must be 0 during byte 5.
- Timeout: with wb_timeout=16, send a read to an address that never acks. cyc must be high for exactly 16 clks, timeout must pulse once, and the host must receive 0xFFFFFFFF.
- Aborted write: raise CS after byte 6 of a write. Expect no cycle. The next full write frame must execute correctly.
- Reset mid-cycle: assert reset while cyc=1. All outputs must go to 0 immediately (asynchronously). After reset release, a read frame must work.
- Back-to-back with stalled ack: send two write frames with an ack delay longer than one frame time. The second cycle must start 1 clk after the first ends and carry the second frame's address and data.
